// File: rtl/paint_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : paint_pkg
//  Description : Shared definitions for the retro-paint input front-end:
//                FSM state encoding, button index constants (index order is
//                also the service priority), default widths and the pending
//                priority picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package paint_pkg;

  localparam int unsigned DEF_COORD_W = 6;
  localparam int unsigned DEF_PAL_W   = 3;
  localparam int unsigned NUM_BTNS    = 6;

  // Lower index wins when several events are pending.
  localparam logic [2:0] BTN_ENTER = 3'd0;
  localparam logic [2:0] BTN_C     = 3'd1;
  localparam logic [2:0] BTN_UP    = 3'd2;
  localparam logic [2:0] BTN_DOWN  = 3'd3;
  localparam logic [2:0] BTN_LEFT  = 3'd4;
  localparam logic [2:0] BTN_RIGHT = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMMIT    = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Index of the highest-priority (lowest-index) set bit; 0 when none set.
  function automatic logic [2:0] pick_event(input logic [NUM_BTNS-1:0] pend);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (pend[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage : paint_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer, stable-level counter and rising-edge
//                pulse for one raw push-button.
//  Ports       : clk, rst    - clock, async active-high reset
//                btn_i       - raw asynchronous button level
//                rise_o      - one-cycle pulse on accepted 0->1 transition
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  // Only two levels exist, so "synchronized differs from accepted" means a
  // single candidate level; any flip back to the accepted level restarts
  // the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == c_last_cnt) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/paint_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : paint_input_ctrl
//  Description : Button front-end for the paint controller. Debounces six
//                buttons, keeps sticky pending events, serves one event per
//                transaction (in_init pulse, hold outputs, wait in_done) and
//                owns the canvas cursor, palette cursor and palette mode.
//  Ports       : clk, rst              - clock, async active-high reset
//                btn_*                 - raw buttons
//                in_done               - transaction finished (1-cycle pulse)
//                in_init               - transaction start (1-cycle pulse)
//                w_C, w_Enter          - palette mode / Enter transaction
//                x_out, y_out, paleta  - canvas and palette cursors
//                busy                  - transaction in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module paint_input_ctrl
  import paint_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned COORD_W         = DEF_COORD_W,
  parameter int unsigned PAL_W           = DEF_PAL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_c,
  input  logic               btn_enter,
  input  logic               in_done,
  output logic               in_init,
  output logic               w_C,
  output logic               w_Enter,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic [PAL_W-1:0]   paleta,
  output logic               busy
);

  localparam logic [COORD_W-1:0] c_xy_one  = COORD_W'(1);
  localparam logic [PAL_W-1:0]   c_pal_one = PAL_W'(1);

  logic [NUM_BTNS-1:0] w_btn_raw;
  logic [NUM_BTNS-1:0] w_btn_rise;

  assign w_btn_raw[BTN_ENTER] = btn_enter;
  assign w_btn_raw[BTN_C]     = btn_c;
  assign w_btn_raw[BTN_UP]    = btn_up;
  assign w_btn_raw[BTN_DOWN]  = btn_down;
  assign w_btn_raw[BTN_LEFT]  = btn_left;
  assign w_btn_raw[BTN_RIGHT] = btn_right;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (w_btn_raw[g]),
      .rise_o (w_btn_rise[g])
    );
  end

  state_t              state_q, state_d;
  logic [NUM_BTNS-1:0] pend_q, pend_d;
  logic [2:0]          ev_q, ev_d;
  logic                mode_q, mode_d;
  logic                enter_q, enter_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic [PAL_W-1:0]    pal_q, pal_d;
  logic [NUM_BTNS-1:0] w_clr;

  always_comb begin
    state_d = state_q;
    ev_d    = ev_q;
    mode_d  = mode_q;
    enter_d = enter_q;
    x_d     = x_q;
    y_d     = y_q;
    pal_d   = pal_q;
    w_clr   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          ev_d    = pick_event(pend_q);
          w_clr   = NUM_BTNS'(1) << ev_d;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        unique case (ev_q)
          BTN_ENTER: enter_d = 1'b1;
          BTN_C:     mode_d  = ~mode_q;
          BTN_UP:    if (!mode_q) y_d = y_q - c_xy_one;
          BTN_DOWN:  if (!mode_q) y_d = y_q + c_xy_one;
          BTN_LEFT: begin
            if (mode_q) pal_d = pal_q - c_pal_one;
            else        x_d   = x_q - c_xy_one;
          end
          BTN_RIGHT: begin
            if (mode_q) pal_d = pal_q + c_pal_one;
            else        x_d   = x_q + c_xy_one;
          end
          default: ;
        endcase
        state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (in_done) begin
          enter_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh edge on the bit being consumed survives as a new press.
    pend_d = (pend_q & ~w_clr) | w_btn_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ev_q    <= 3'd0;
      mode_q  <= 1'b0;
      enter_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      pal_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ev_q    <= ev_d;
      mode_q  <= mode_d;
      enter_q <= enter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pal_q   <= pal_d;
    end
  end

  assign in_init = (state_q == ST_ISSUE);
  assign busy    = (state_q != ST_IDLE);
  assign w_C     = mode_q;
  assign w_Enter = enter_q;
  assign x_out   = x_q;
  assign y_out   = y_q;
  assign paleta  = pal_q;

endmodule : paint_input_ctrl
`default_nettype wire

// File: tb/tb_paint_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paint_input_ctrl
//  Description : Directed self-checking bench for paint_input_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paint_input_ctrl;

  localparam int B_ENTER = 0;
  localparam int B_C     = 1;
  localparam int B_UP    = 2;
  localparam int B_DOWN  = 3;
  localparam int B_LEFT  = 4;
  localparam int B_RIGHT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] btn = '0;
  logic       in_done = 1'b0;
  logic       in_init, w_C, w_Enter, busy;
  logic [5:0] x_out, y_out;
  logic [2:0] paleta;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  paint_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .COORD_W         (6),
    .PAL_W           (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn[B_UP]),
    .btn_down  (btn[B_DOWN]),
    .btn_left  (btn[B_LEFT]),
    .btn_right (btn[B_RIGHT]),
    .btn_c     (btn[B_C]),
    .btn_enter (btn[B_ENTER]),
    .in_done   (in_done),
    .in_init   (in_init),
    .w_C       (w_C),
    .w_Enter   (w_Enter),
    .x_out     (x_out),
    .y_out     (y_out),
    .paleta    (paleta),
    .busy      (busy)
  );

  // Wait (bounded) for an in_init pulse; returns negedges waited.
  task automatic wait_init(input int limit, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (in_init) begin
        ok = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  // Press a button, wait for its transaction to issue, release the button.
  task automatic press(input int b, output bit ok);
    int c;
    @(negedge clk);
    btn[b] = 1'b1;
    wait_init(60, ok, c);
    btn[b] = 1'b0;
  endtask

  // Acknowledge the transaction and let the released button settle low.
  task automatic finish_txn();
    repeat (3) @(negedge clk);
    in_done = 1'b1;
    @(negedge clk);
    in_done = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({in_init, w_C, w_Enter, busy, x_out, y_out, paleta} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0",
               {in_init, w_C, w_Enter, busy, x_out, y_out, paleta});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_right();
    bit ok;
    press(B_RIGHT, ok);
    total++;
    if (!ok || x_out !== 6'd1 || y_out !== 6'd0 || w_C !== 1'b0 || w_Enter !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL right_press: ok=%0d x=%0d y=%0d wC=%b wE=%b busy=%b want ok=1 x=1 y=0 wC=0 wE=0 busy=1",
               ok, x_out, y_out, w_C, w_Enter, busy);
    end
    @(negedge clk);
    total++;
    if (in_init !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL init_one_cycle: in_init=%b busy=%b want 0 1", in_init, busy);
    end
    repeat (2) @(negedge clk);
    in_done = 1'b1;
    @(negedge clk);
    in_done = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_after_done: got %b want 0", busy);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok;
    press(B_LEFT, ok);  finish_txn();   // x 1 -> 0
    press(B_LEFT, ok);                  // x 0 -> 63
    total++;
    if (!ok || x_out !== 6'd63) begin
      bad++;
      $display("FAIL x_wrap_down: ok=%0d x=%0d want 63", ok, x_out);
    end
    finish_txn();
    press(B_RIGHT, ok);
    total++;
    if (!ok || x_out !== 6'd0) begin
      bad++;
      $display("FAIL x_wrap_up: ok=%0d x=%0d want 0", ok, x_out);
    end
    finish_txn();
    press(B_UP, ok);
    total++;
    if (!ok || y_out !== 6'd63 || x_out !== 6'd0) begin
      bad++;
      $display("FAIL y_wrap_up: ok=%0d y=%0d x=%0d want y=63 x=0", ok, y_out, x_out);
    end
    finish_txn();
  endtask

  task automatic test_palette();
    bit ok;
    press(B_C, ok);
    total++;
    if (!ok || w_C !== 1'b1 || paleta !== 3'd0) begin
      bad++;
      $display("FAIL palette_enter: ok=%0d wC=%b pal=%0d want 1 0", ok, w_C, paleta);
    end
    finish_txn();
    press(B_RIGHT, ok); finish_txn();
    press(B_RIGHT, ok);
    total++;
    if (!ok || w_C !== 1'b1 || paleta !== 3'd2 || x_out !== 6'd0 || y_out !== 6'd63) begin
      bad++;
      $display("FAIL palette_right: ok=%0d wC=%b pal=%0d x=%0d y=%0d want 1 2 0 63",
               ok, w_C, paleta, x_out, y_out);
    end
    finish_txn();
    press(B_ENTER, ok);
    total++;
    if (!ok || w_Enter !== 1'b1 || w_C !== 1'b1) begin
      bad++;
      $display("FAIL palette_enter_txn: ok=%0d wE=%b wC=%b want 1 1", ok, w_Enter, w_C);
    end
    finish_txn();
    total++;
    if (w_Enter !== 1'b0) begin
      bad++;
      $display("FAIL enter_clears: wE=%b want 0", w_Enter);
    end
    press(B_C, ok);
    total++;
    if (!ok || w_C !== 1'b0 || paleta !== 3'd2) begin
      bad++;
      $display("FAIL palette_exit: ok=%0d wC=%b pal=%0d want 0 2", ok, w_C, paleta);
    end
    finish_txn();
  endtask

  task automatic test_bounce();
    bit ok;
    int c;
    int extra;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); btn[B_LEFT] = 1'b1;
      @(negedge clk);
      @(negedge clk); btn[B_LEFT] = 1'b0;
      @(negedge clk);
    end
    @(negedge clk); btn[B_LEFT] = 1'b1;
    wait_init(60, ok, c);
    repeat (5) @(negedge clk);
    btn[B_LEFT] = 1'b0;
    total++;
    if (!ok || x_out !== 6'd63) begin
      bad++;
      $display("FAIL bounce_once: ok=%0d x=%0d want 63", ok, x_out);
    end
    finish_txn();
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_init) extra++;
    end
    total++;
    if (extra !== 0 || x_out !== 6'd63) begin
      bad++;
      $display("FAIL bounce_no_extra: pulses=%0d x=%0d want 0 63", extra, x_out);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int c;
    int early;
    press(B_RIGHT, ok);                 // x 63 -> 0, now in WAIT_DONE
    @(negedge clk);
    btn[B_ENTER] = 1'b1;
    btn[B_DOWN]  = 1'b1;
    early = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (in_init) early++;
    end
    btn[B_ENTER] = 1'b0;
    btn[B_DOWN]  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (in_init) early++;
    end
    total++;
    if (early !== 0 || busy !== 1'b1 || w_Enter !== 1'b0 || x_out !== 6'd0) begin
      bad++;
      $display("FAIL wait_frozen: pulses=%0d busy=%b wE=%b x=%0d want 0 1 0 0",
               early, busy, w_Enter, x_out);
    end
    in_done = 1'b1;
    @(negedge clk);
    in_done = 1'b0;
    wait_init(20, ok, c);
    total++;
    if (!ok || c !== 2 || w_Enter !== 1'b1 || y_out !== 6'd63) begin
      bad++;
      $display("FAIL b2b_enter_first: ok=%0d gap=%0d wE=%b y=%0d want 1 gap=2(3 cyc) 1 63",
               ok, c, w_Enter, y_out);
    end
    repeat (2) @(negedge clk);
    in_done = 1'b1;
    @(negedge clk);
    in_done = 1'b0;
    wait_init(20, ok, c);
    total++;
    if (!ok || c !== 2 || w_Enter !== 1'b0 || y_out !== 6'd0) begin
      bad++;
      $display("FAIL b2b_down_second: ok=%0d gap=%0d wE=%b y=%0d want 1 gap=2(3 cyc) 0 0",
               ok, c, w_Enter, y_out);
    end
    finish_txn();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c;
    press(B_DOWN, ok);                  // y 0 -> 1, WAIT_DONE
    total++;
    if (!ok || y_out !== 6'd1) begin
      bad++;
      $display("FAIL pre_reset_down: ok=%0d y=%0d want 1", ok, y_out);
    end
    @(negedge clk);
    btn[B_DOWN] = 1'b1;
    repeat (10) @(negedge clk);
    btn[B_DOWN] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({in_init, w_C, w_Enter, busy, x_out, y_out, paleta} !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid_txn: got %b want 0",
               {in_init, w_C, w_Enter, busy, x_out, y_out, paleta});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_init(30, ok, c);
    total++;
    if (ok || busy !== 1'b0) begin
      bad++;
      $display("FAIL no_init_after_reset: init_seen=%0d busy=%b want 0 0", ok, busy);
    end
    press(B_RIGHT, ok);
    total++;
    if (!ok || x_out !== 6'd1 || y_out !== 6'd0) begin
      bad++;
      $display("FAIL press_after_reset: ok=%0d x=%0d y=%0d want 1 1 0", ok, x_out, y_out);
    end
    finish_txn();
  endtask

  initial begin
    test_reset();
    test_single_right();
    test_wrap();
    test_palette();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_paint_input_ctrl
`default_nettype wire
